// File: rtl/sfu_pool_acc_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sfu_pool_acc_if
// Description : Lane bus between the systolic-array columns, the special-
//               function unit and the output SRAM write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface sfu_pool_acc_if #(
    parameter int PSUM_BW = 16,
    parameter int COL     = 8,
    parameter int CNT_BW  = 4
);
    logic [1:0]             mode_i;
    logic [CNT_BW-1:0]      acc_len_i;
    logic [CNT_BW-1:0]      pool_len_i;
    logic                   clear_i;
    logic                   in_valid_i;
    logic [COL*PSUM_BW-1:0] psum_in;
    logic                   out_valid_o;
    logic [COL*PSUM_BW-1:0] psum_out;
    logic                   busy_o;

    modport master (
        output mode_i, acc_len_i, pool_len_i, clear_i, in_valid_i, psum_in,
        input  out_valid_o, psum_out, busy_o
    );

    modport slave (
        input  mode_i, acc_len_i, pool_len_i, clear_i, in_valid_i, psum_in,
        output out_valid_o, psum_out, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/sfu_pool_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sfu_pool_acc
// Description : Per-lane bypass / ReLU / accumulate+ReLU / accumulate+ReLU+
//               max-pool at the systolic-array output. Define SFU_SAT_EN for
//               saturating lane adds (wrapping otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module sfu_pool_acc #(
    parameter int PSUM_BW = 16,
    parameter int COL     = 8,
    parameter int CNT_BW  = 4
) (
    input  wire logic clk,
    input  wire logic reset_n,
    sfu_pool_acc_if.slave bus
);
    localparam int                c_VEC_W    = COL * PSUM_BW;
    localparam logic [1:0]        c_MODE_BYP  = 2'b00;
    localparam logic [1:0]        c_MODE_RELU = 2'b01;
    localparam logic [1:0]        c_MODE_ACC  = 2'b10;
    localparam logic [CNT_BW-1:0] c_CNT_ONE   = 1;
`ifdef SFU_SAT_EN
    localparam logic [PSUM_BW-1:0] c_SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] c_SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};
`endif

    logic [1:0]         r_mode;
    logic [CNT_BW-1:0]  r_acc_len;
    logic [CNT_BW-1:0]  r_pool_len;
    logic [CNT_BW-1:0]  r_acc_cnt;
    logic [CNT_BW-1:0]  r_pool_cnt;
    logic [c_VEC_W-1:0] r_acc_q;
    logic [c_VEC_W-1:0] r_pool_q;
    logic               r_out_valid;
    logic [c_VEC_W-1:0] r_psum_out;

    logic               w_busy;
    logic [1:0]         w_mode;
    logic [CNT_BW-1:0]  w_acc_len;
    logic [CNT_BW-1:0]  w_pool_len;
    logic [CNT_BW-1:0]  w_acc_lim;
    logic [CNT_BW-1:0]  w_pool_lim;
    logic               w_acc_first;
    logic               w_pool_first;
    logic               w_acc_last;
    logic               w_pool_last;
    logic [c_VEC_W-1:0] w_sum_v;
    logic [c_VEC_W-1:0] w_relu_in_v;
    logic [c_VEC_W-1:0] w_relu_sum_v;
    logic [c_VEC_W-1:0] w_max_v;

    assign w_busy = (r_acc_cnt != '0) || (r_pool_cnt != '0);

    // An idle unit takes its configuration from the beat that opens the window.
    assign w_mode     = w_busy ? r_mode     : bus.mode_i;
    assign w_acc_len  = w_busy ? r_acc_len  : bus.acc_len_i;
    assign w_pool_len = w_busy ? r_pool_len : bus.pool_len_i;

    assign w_acc_lim    = (w_acc_len  == '0) ? '0 : w_acc_len  - c_CNT_ONE;
    assign w_pool_lim   = (w_pool_len == '0) ? '0 : w_pool_len - c_CNT_ONE;
    assign w_acc_first  = (r_acc_cnt  == '0);
    assign w_pool_first = (r_pool_cnt == '0);
    assign w_acc_last   = (r_acc_cnt  == w_acc_lim);
    assign w_pool_last  = (r_pool_cnt == w_pool_lim);

    for (genvar k = 0; k < COL; k++) begin : g_lane
        logic signed [PSUM_BW-1:0] w_in;
        logic signed [PSUM_BW-1:0] w_acc;
        logic signed [PSUM_BW-1:0] w_pool;
        logic signed [PSUM_BW-1:0] w_add;
        logic signed [PSUM_BW-1:0] w_sum;
        logic signed [PSUM_BW-1:0] w_relu_sum;

        assign w_in   = bus.psum_in[k*PSUM_BW +: PSUM_BW];
        assign w_acc  = r_acc_q[k*PSUM_BW +: PSUM_BW];
        assign w_pool = r_pool_q[k*PSUM_BW +: PSUM_BW];

`ifdef SFU_SAT_EN
        logic signed [PSUM_BW:0] w_wide;
        assign w_wide = {w_acc[PSUM_BW-1], w_acc} + {w_in[PSUM_BW-1], w_in};
        // Top two bits disagree only when the true sum left the lane range.
        assign w_add  = (w_wide[PSUM_BW] != w_wide[PSUM_BW-1])
                      ? (w_wide[PSUM_BW] ? c_SAT_MIN : c_SAT_MAX)
                      : w_wide[PSUM_BW-1:0];
`else
        assign w_add  = w_acc + w_in;
`endif

        assign w_sum      = w_acc_first ? w_in : w_add;
        assign w_relu_sum = w_sum[PSUM_BW-1] ? '0 : w_sum;

        assign w_sum_v[k*PSUM_BW +: PSUM_BW]      = w_sum;
        assign w_relu_sum_v[k*PSUM_BW +: PSUM_BW] = w_relu_sum;
        assign w_relu_in_v[k*PSUM_BW +: PSUM_BW]  = w_in[PSUM_BW-1] ? '0 : w_in;
        assign w_max_v[k*PSUM_BW +: PSUM_BW]      =
            (w_pool_first || (w_relu_sum > w_pool)) ? w_relu_sum : w_pool;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= c_MODE_BYP;
            r_acc_len   <= '0;
            r_pool_len  <= '0;
            r_acc_cnt   <= '0;
            r_pool_cnt  <= '0;
            r_acc_q     <= '0;
            r_pool_q    <= '0;
            r_out_valid <= 1'b0;
            r_psum_out  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.clear_i) begin
                r_acc_cnt  <= '0;
                r_pool_cnt <= '0;
            end else if (bus.in_valid_i) begin
                if (!w_busy) begin
                    r_mode     <= bus.mode_i;
                    r_acc_len  <= bus.acc_len_i;
                    r_pool_len <= bus.pool_len_i;
                end
                case (w_mode)
                    c_MODE_BYP: begin
                        r_out_valid <= 1'b1;
                        r_psum_out  <= bus.psum_in;
                    end
                    c_MODE_RELU: begin
                        r_out_valid <= 1'b1;
                        r_psum_out  <= w_relu_in_v;
                    end
                    c_MODE_ACC: begin
                        if (w_acc_last) begin
                            r_out_valid <= 1'b1;
                            r_psum_out  <= w_relu_sum_v;
                            r_acc_cnt   <= '0;
                        end else begin
                            r_acc_q   <= w_sum_v;
                            r_acc_cnt <= r_acc_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        if (w_acc_last) begin
                            r_acc_cnt <= '0;
                            if (w_pool_last) begin
                                r_out_valid <= 1'b1;
                                r_psum_out  <= w_max_v;
                                r_pool_cnt  <= '0;
                            end else begin
                                r_pool_q   <= w_max_v;
                                r_pool_cnt <= r_pool_cnt + c_CNT_ONE;
                            end
                        end else begin
                            r_acc_q   <= w_sum_v;
                            r_acc_cnt <= r_acc_cnt + c_CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.out_valid_o = r_out_valid;
    assign bus.psum_out    = r_psum_out;
    assign bus.busy_o      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_sfu_pool_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sfu_pool_acc
// Description : Self-checking bench for sfu_pool_acc (table vectors plus
//               multi-cycle sequences, queue-based result scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfu_pool_acc;
    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int CNT_BW  = 4;
    localparam int VW      = COL * PSUM_BW;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sfu_pool_acc_if #(.PSUM_BW(PSUM_BW), .COL(COL), .CNT_BW(CNT_BW)) bus ();

    sfu_pool_acc #(.PSUM_BW(PSUM_BW), .COL(COL), .CNT_BW(CNT_BW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0]         mode;
        logic [CNT_BW-1:0]  acc_len;
        logic [CNT_BW-1:0]  pool_len;
        logic [PSUM_BW-1:0] din;
        logic [PSUM_BW-1:0] dexp;
    } vec_t;

    vec_t            tbl [10];
    logic [VW-1:0]   exp_q [$];
    int              checks = 0;
    int              errors = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, expv);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, expv);
        end
    endtask

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got out_valid=1 data %h required no pulse", bus.psum_out);
            end else begin
                check("result", bus.psum_out, exp_q.pop_front());
            end
        end
    end

    task automatic cfg(input logic [1:0] m, input logic [CNT_BW-1:0] al, input logic [CNT_BW-1:0] pl);
        bus.mode_i     = m;
        bus.acc_len_i  = al;
        bus.pool_len_i = pl;
    endtask

    task automatic beat_vec(input logic [VW-1:0] v);
        bus.psum_in    = v;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic beat(input logic [PSUM_BW-1:0] v);
        beat_vec({COL{v}});
    endtask

    task automatic beat_exp(input logic [PSUM_BW-1:0] v, input logic [PSUM_BW-1:0] e);
        exp_q.push_back({COL{e}});
        beat(v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [VW-1:0] mixed_in;
        logic [VW-1:0] mixed_exp;

        tbl[0] = '{2'b00, 4'd1, 4'd1, 16'hFFFB, 16'hFFFB};
        tbl[1] = '{2'b01, 4'd1, 4'd1, 16'hFFFB, 16'h0000};
        tbl[2] = '{2'b01, 4'd1, 4'd1, 16'h0012, 16'h0012};
        tbl[3] = '{2'b00, 4'd1, 4'd1, 16'h8000, 16'h8000};
        tbl[4] = '{2'b01, 4'd1, 4'd1, 16'h7FFF, 16'h7FFF};
        tbl[5] = '{2'b01, 4'd1, 4'd1, 16'h8000, 16'h0000};
        tbl[6] = '{2'b10, 4'd1, 4'd1, 16'hFFF0, 16'h0000};
        tbl[7] = '{2'b10, 4'd0, 4'd0, 16'h0040, 16'h0040};
        tbl[8] = '{2'b11, 4'd1, 4'd0, 16'hFFF0, 16'h0000};
        tbl[9] = '{2'b11, 4'd0, 4'd1, 16'h0005, 16'h0005};

        cfg(2'b00, 4'd0, 4'd0);
        bus.clear_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.psum_in    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_bit("reset_out_valid", bus.out_valid_o, 1'b0);
        check("reset_psum_out", bus.psum_out, '0);
        check_bit("reset_busy", bus.busy_o, 1'b0);
        reset_n = 1'b1;
        idle(1);

        // Single-beat vectors, issued back to back
        for (int i = 0; i < 10; i++) begin
            cfg(tbl[i].mode, tbl[i].acc_len, tbl[i].pool_len);
            beat_exp(tbl[i].din, tbl[i].dexp);
        end
        drain();

        // Lanes are independent: alternate negative / positive lanes
        for (int k = 0; k < COL; k++) begin
            if (k % 2 == 1) begin
                mixed_in[k*PSUM_BW +: PSUM_BW]  = 16'(100 * k);
                mixed_exp[k*PSUM_BW +: PSUM_BW] = 16'(100 * k);
            end else begin
                mixed_in[k*PSUM_BW +: PSUM_BW]  = -16'(k + 1);
                mixed_exp[k*PSUM_BW +: PSUM_BW] = 16'h0000;
            end
        end
        cfg(2'b01, 4'd1, 4'd1);
        exp_q.push_back(mixed_exp);
        beat_vec(mixed_in);
        drain();

        // Accumulate L=3 with gaps
        cfg(2'b10, 4'd3, 4'd1);
        beat(16'd10);
        idle(2);
        check_bit("acc_busy_gap", bus.busy_o, 1'b1);
        beat(16'd20);
        idle(2);
        beat_exp(16'hFFFB, 16'd25);
        check_bit("acc_busy_done", bus.busy_o, 1'b0);
        drain();
        check("hold_value", bus.psum_out, {COL{16'd25}});
        check_bit("hold_valid_low", bus.out_valid_o, 1'b0);
        beat(16'hFFF6);
        beat(16'hFFEC);
        beat_exp(16'd5, 16'd0);
        drain();

        // Max-pool L=2 P=2
        cfg(2'b11, 4'd2, 4'd2);
        beat(16'd3);
        beat(16'd4);
        check_bit("pool_busy_mid", bus.busy_o, 1'b1);
        beat(16'd10);
        beat_exp(16'hFFEC, 16'd7);
        beat(16'd1);
        beat(16'd1);
        beat(16'd50);
        beat_exp(16'd0, 16'd50);
        drain();

        // Saturating vs wrapping add
        cfg(2'b10, 4'd2, 4'd1);
        beat(16'd30000);
`ifdef SFU_SAT_EN
        beat_exp(16'd30000, 16'h7FFF);
`else
        beat_exp(16'd30000, 16'h0000);
`endif
        beat(-16'd30000);
`ifdef SFU_SAT_EN
        beat_exp(-16'd30000, 16'h0000);
`else
        beat_exp(-16'd30000, 16'd5536);
`endif
        drain();

        // Config change mid-window is ignored
        cfg(2'b10, 4'd3, 4'd1);
        beat(16'd1);
        check_bit("cfg_busy", bus.busy_o, 1'b1);
        cfg(2'b00, 4'd1, 4'd1);
        beat(16'd1);
        beat_exp(16'd1, 16'd3);
        drain();

        // Clear alongside a valid beat drops the partial window
        cfg(2'b10, 4'd3, 4'd1);
        beat(16'd1);
        beat(16'd1);
        bus.clear_i = 1'b1;
        beat(16'd1);
        bus.clear_i = 1'b0;
        check_bit("clear_busy", bus.busy_o, 1'b0);
        check_bit("clear_no_pulse", bus.out_valid_o, 1'b0);
        idle(2);
        beat(16'd1);
        beat(16'd1);
        beat_exp(16'd1, 16'd3);
        drain();

        // Asynchronous reset in the middle of a pool window
        cfg(2'b11, 4'd2, 4'd2);
        beat(16'd5);
        beat(16'd5);
        beat(16'd5);
        check_bit("prereset_busy", bus.busy_o, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_psum", bus.psum_out, '0);
        check_bit("async_reset_valid", bus.out_valid_o, 1'b0);
        check_bit("async_reset_busy", bus.busy_o, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        cfg(2'b00, 4'd1, 4'd1);
        beat_exp(16'hFFFB, 16'hFFFB);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
